// File: rtl/vga_capture_rx_if.sv
// vga_capture_rx_if: VGA input pins plus frame-buffer write port and lock status of the capture receiver
interface vga_capture_rx_if #(parameter int ADDR_W = 15);
  logic              hsync;
  logic              vsync;
  logic [2:0]        red;
  logic [2:0]        green;
  logic [1:0]        blue;
  logic              locked;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic              frame_done;
  logic [7:0]        err_cnt;
  modport master (output hsync, vsync, red, green, blue,
                  input locked, wr_en, wr_addr, wr_data, frame_done, err_cnt);
  modport slave  (input hsync, vsync, red, green, blue,
                  output locked, wr_en, wr_addr, wr_data, frame_done, err_cnt);
endinterface

// File: rtl/vga_capture_rx.sv
// vga_capture_rx: locks to VGA sync timing, decimates the active area 4x4 and writes recovered pixel codes
module vga_capture_rx #(
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int HBP     = 144,
  parameter int VBP     = 31,
  parameter int ACT_W   = 640,
  parameter int ACT_H   = 480,
  parameter int ADDR_W  = 15
) (
  input logic              dclk,
  input logic              clr_n,
  vga_capture_rx_if.slave  vga
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  localparam logic [9:0]        H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0]        V_LAST = 10'(VLINES - 1);
  localparam logic [9:0]        H_BEG  = 10'(HBP);
  localparam logic [9:0]        H_END  = 10'(HBP + ACT_W);
  localparam logic [9:0]        V_BEG  = 10'(VBP);
  localparam logic [9:0]        V_END  = 10'(VBP + ACT_H);
  localparam logic [ADDR_W-1:0] PX_W   = ADDR_W'(ACT_W >> 2);
  state_t            state_q, state_d;
  logic              bad_q, bad_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              s_hsync_q, s_vsync_q, v_last_q;
  logic [7:0]        s_rgb_q;
  logic              h_edge_q, v_edge_q, line_err_q, frame_err_q;
  logic [9:0]        hc_q, vc_q;
  logic              wr_en_q, frame_done_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [2:0]        wr_data_q;
  logic              h_edge_in, v_edge_in, err, cap;
  logic [9:0]        hx, vy;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        code;
  // edges are decoded from the raw pins so the counters already read 0 when s_hsync first shows the edge
  assign h_edge_in = !vga.hsync && s_hsync_q;
  assign v_edge_in = h_edge_in && !vga.vsync && v_last_q;
  assign err       = line_err_q || frame_err_q;
  assign hx        = hc_q - H_BEG;
  assign vy        = vc_q - V_BEG;
  assign cap       = state_q == LOCKED && hc_q >= H_BEG && hc_q < H_END && vc_q >= V_BEG && vc_q < V_END
                     && hx[1:0] == 2'd0 && vy[1:0] == 2'd0;
  assign addr      = ADDR_W'(vy[9:2]) * PX_W + ADDR_W'(hx[9:2]);
  assign code      = s_rgb_q == 8'h00 ? 3'd0 :
                     s_rgb_q == 8'hE0 ? 3'd1 :
                     s_rgb_q == 8'hF4 ? 3'd2 :
                     s_rgb_q == 8'hF8 ? 3'd3 :
                     s_rgb_q == 8'h92 ? 3'd5 : 3'd7;
  always_comb begin
    state_d   = state_q;
    bad_d     = bad_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      SEARCH: if (v_edge_q) begin
        state_d = MEASURE;
        bad_d   = 1'b0;
      end
      MEASURE: if (v_edge_q) begin
        state_d = (bad_q || err) ? MEASURE : LOCKED;
        bad_d   = 1'b0;
      end else bad_d = bad_q || err;
      LOCKED: if (err) begin
        state_d   = SEARCH;
        err_cnt_d = err_cnt_q + {7'd0, err_cnt_q != 8'hFF};
      end
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= SEARCH;
      bad_q        <= 1'b0;
      err_cnt_q    <= 8'd0;
      s_hsync_q    <= 1'b0;
      s_vsync_q    <= 1'b0;
      s_rgb_q      <= 8'd0;
      v_last_q     <= 1'b0;
      h_edge_q     <= 1'b0;
      v_edge_q     <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      hc_q         <= 10'd0;
      vc_q         <= 10'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bad_q        <= bad_d;
      err_cnt_q    <= err_cnt_d;
      s_hsync_q    <= vga.hsync;
      s_vsync_q    <= vga.vsync;
      s_rgb_q      <= {vga.red, vga.green, vga.blue};
      h_edge_q     <= h_edge_in;
      v_edge_q     <= v_edge_in;
      if (h_edge_q) v_last_q <= s_vsync_q;
      hc_q         <= h_edge_in ? 10'd0 : hc_q + {9'd0, hc_q != 10'h3FF};
      if (h_edge_in) vc_q <= v_edge_in ? 10'd0 : vc_q + {9'd0, vc_q != 10'h3FF};
      line_err_q   <= h_edge_in ? hc_q != H_LAST : hc_q == H_LAST;
      frame_err_q  <= v_edge_in ? vc_q != V_LAST : h_edge_in && vc_q == V_LAST;
      wr_en_q      <= cap;
      if (cap) begin
        wr_addr_q <= addr;
        wr_data_q <= code;
      end
      frame_done_q <= state_q == LOCKED && h_edge_q && vc_q == V_END && !err;
    end
  end
  assign vga.locked     = state_q == LOCKED;
  assign vga.wr_en      = wr_en_q;
  assign vga.wr_addr    = wr_addr_q;
  assign vga.wr_data    = wr_data_q;
  assign vga.frame_done = frame_done_q;
  assign vga.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_vga_capture_rx.sv
// tb_vga_capture_rx: drives a scaled-down VGA raster and scoreboards the frame-buffer writes
module tb_vga_capture_rx;
  localparam int HP = 48, VL = 40, HB = 12, VB = 5, AW = 32, AH = 32;
  localparam int PXW = AW / 4, PXH = AH / 4, HS = 6, VS = 2;
  logic dclk = 1'b0;
  logic clr_n = 1'b0;
  always #5 dclk = ~dclk;
  vga_capture_rx_if #(.ADDR_W(15)) vga ();
  vga_capture_rx #(.HPIXELS(HP), .VLINES(VL), .HBP(HB), .VBP(VB), .ACT_W(AW), .ACT_H(AH), .ADDR_W(15))
    dut (.dclk(dclk), .clr_n(clr_n), .vga(vga));
  int checks = 0, failures = 0;
  int cyc = 0, ls_cyc = 0, rise_cyc = -1, fall_cyc = -1, rise_cnt = 0;
  int wr_cnt = 0, fd_cnt = 0, code2_addr = -1, mode = 0;
  logic lk_prev = 1'b0;
  logic [17:0] sb[$];
  always @(posedge dclk) cyc <= cyc + 1;
  function automatic logic [7:0] color(input int ax, input int ay);
    if (mode == 0) return 8'hE0;
    if (mode == 1) return (ax == 8 && ay == 4) ? 8'hF4 : 8'h00;
    return 8'h1C;
  endfunction
  function automatic logic [2:0] code_of(input logic [7:0] c);
    case (c)
      8'h00: return 3'd0;
      8'hE0: return 3'd1;
      8'hF4: return 3'd2;
      8'hF8: return 3'd3;
      8'h92: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction
  always @(negedge dclk) begin
    logic [17:0] exp;
    if (vga.locked && !lk_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (!vga.locked && lk_prev) fall_cyc = cyc;
    lk_prev = vga.locked;
    if (vga.frame_done) fd_cnt++;
    if (vga.wr_en) begin
      wr_cnt++;
      checks++;
      if (vga.wr_data == 3'd2) code2_addr = int'(vga.wr_addr);
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wr addr=%0d data=%0d required=no write", vga.wr_addr, vga.wr_data);
      end else begin
        exp = sb.pop_front();
        if ({vga.wr_addr, vga.wr_data} !== exp) begin
          failures++;
          $display("FAIL wr addr=%0d data=%0d required addr=%0d data=%0d",
                   vga.wr_addr, vga.wr_data, exp[17:3], exp[2:0]);
        end
      end
    end
  end
  task automatic gen_line(input int y, input int len, input bit hs_on, input bit cap, input int rst_x);
    for (int x = 0; x < len; x++) begin
      int ax, ay;
      bit act;
      logic [7:0] c;
      @(negedge dclk);
      if (x == 0) ls_cyc = cyc;
      ax = x - HB;
      ay = y - VB;
      act = ax >= 0 && ax < AW && ay >= 0 && ay < AH;
      c = act ? color(ax, ay) : 8'h00;
      vga.hsync = !(hs_on && x < HS);
      vga.vsync = !(y < VS);
      {vga.red, vga.green, vga.blue} = c;
      if (cap && act && ax % 4 == 0 && ay % 4 == 0)
        sb.push_back({15'((ay / 4) * PXW + ax / 4), code_of(c)});
      if (x == rst_x) begin
        #1 clr_n = 1'b0;
        #1;
        checks++;
        if ({vga.locked, vga.wr_en, vga.frame_done, vga.wr_addr, vga.wr_data, vga.err_cnt} !== '0) begin
          failures++;
          $display("FAIL async_clear locked=%0b wr_en=%0b fd=%0b addr=%0d data=%0d err_cnt=%0d required all 0",
                   vga.locked, vga.wr_en, vga.frame_done, vga.wr_addr, vga.wr_data, vga.err_cnt);
        end
        #1 clr_n = 1'b1;
      end
    end
  endtask
  task automatic gen_frame(input int nl, input bit cap, output int t0);
    t0 = 0;
    for (int y = 0; y < nl; y++) begin
      gen_line(y, HP, 1'b1, cap, -1);
      if (y == 0) t0 = ls_cyc;
    end
  endtask
  task automatic test_reset();
    vga.hsync = 1'b1;
    vga.vsync = 1'b1;
    {vga.red, vga.green, vga.blue} = 8'h00;
    clr_n = 1'b0;
    repeat (3) @(negedge dclk);
    checks++;
    if ({vga.locked, vga.wr_en, vga.frame_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000", {vga.locked, vga.wr_en, vga.frame_done});
    end
    checks++;
    if ({vga.err_cnt, vga.wr_addr, vga.wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_values err_cnt=%0d addr=%0d data=%0d required 0", vga.err_cnt, vga.wr_addr, vga.wr_data);
    end
    clr_n = 1'b1;
    repeat (4) @(negedge dclk);
  endtask
  task automatic test_lock();
    int t0;
    mode = 0;
    for (int y = VL - 3; y < VL; y++) gen_line(y, HP, 1'b1, 1'b0, -1);
    gen_frame(VL, 1'b0, t0);
    checks++;
    if (vga.locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_measuring locked=%0b required=0", vga.locked);
    end
    wr_cnt = 0;
    fd_cnt = 0;
    gen_frame(VL, 1'b1, t0);
    checks++;
    if (rise_cyc !== t0 + 2) begin
      failures++;
      $display("FAIL lock_rise_cycle got=%0d required=%0d", rise_cyc, t0 + 2);
    end
    checks++;
    if (wr_cnt !== PXW * PXH) begin
      failures++;
      $display("FAIL lock_wr_count got=%0d required=%0d", wr_cnt, PXW * PXH);
    end
    checks++;
    if (fd_cnt !== 1) begin
      failures++;
      $display("FAIL lock_frame_done got=%0d required=1", fd_cnt);
    end
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL lock_missing_wr pending=%0d required=0", sb.size());
    end
  endtask
  task automatic test_pixel();
    int t0;
    mode = 1;
    code2_addr = -1;
    gen_frame(VL, 1'b1, t0);
    checks++;
    if (code2_addr !== (4 / 4) * PXW + 8 / 4) begin
      failures++;
      $display("FAIL pixel_addr got=%0d required=%0d", code2_addr, (4 / 4) * PXW + 8 / 4);
    end
    checks++;
    if (sb.size() !== 0 || vga.locked !== 1'b1) begin
      failures++;
      $display("FAIL pixel_frame pending=%0d locked=%0b required 0 and 1", sb.size(), vga.locked);
    end
  endtask
  task automatic test_short_line();
    int t0, tf;
    localparam int SL = 12;
    mode = 0;
    tf = 0;
    for (int y = 0; y < VL; y++) begin
      gen_line(y, y == SL ? HP - 1 : HP, 1'b1, y <= SL, -1);
      if (y == SL + 1) tf = ls_cyc;
    end
    checks++;
    if (fall_cyc !== tf + 2) begin
      failures++;
      $display("FAIL short_fall_cycle got=%0d required=%0d", fall_cyc, tf + 2);
    end
    checks++;
    if (vga.err_cnt !== 8'd1 || vga.locked !== 1'b0) begin
      failures++;
      $display("FAIL short_err err_cnt=%0d locked=%0b required 1 and 0", vga.err_cnt, vga.locked);
    end
    gen_frame(VL, 1'b0, t0);
    checks++;
    if (vga.locked !== 1'b0) begin
      failures++;
      $display("FAIL short_measuring locked=%0b required=0", vga.locked);
    end
    gen_frame(VL, 1'b1, t0);
    checks++;
    if (rise_cyc !== t0 + 2 || sb.size() !== 0) begin
      failures++;
      $display("FAIL short_relock rise=%0d pending=%0d required %0d and 0", rise_cyc, sb.size(), t0 + 2);
    end
  endtask
  task automatic test_hold();
    int t0;
    localparam int HL = 10;
    mode = 0;
    for (int y = 0; y < VL; y++) begin
      if (y == HL) begin
        gen_line(y, 1100, 1'b0, 1'b0, -1);
        checks++;
        if (dut.hc_q !== 10'd1023) begin
          failures++;
          $display("FAIL hold_hc_sat got=%0d required=1023", dut.hc_q);
        end
        checks++;
        if (vga.locked !== 1'b0 || vga.err_cnt !== 8'd2) begin
          failures++;
          $display("FAIL hold_err locked=%0b err_cnt=%0d required 0 and 2", vga.locked, vga.err_cnt);
        end
      end else gen_line(y, HP, 1'b1, y < HL, -1);
    end
    gen_frame(VL, 1'b0, t0);
    gen_frame(VL, 1'b1, t0);
    checks++;
    if (rise_cyc !== t0 + 2 || sb.size() !== 0) begin
      failures++;
      $display("FAIL hold_relock rise=%0d pending=%0d required %0d and 0", rise_cyc, sb.size(), t0 + 2);
    end
  endtask
  task automatic test_async_clear();
    int t0;
    localparam int RL = 10, RX = 20;
    mode = 0;
    for (int y = 0; y < VL; y++) gen_line(y, HP, 1'b1, y < RL, y == RL ? RX : -1);
    checks++;
    if (vga.err_cnt !== 8'd0 || vga.locked !== 1'b0) begin
      failures++;
      $display("FAIL clear_after err_cnt=%0d locked=%0b required 0 and 0", vga.err_cnt, vga.locked);
    end
    gen_frame(VL, 1'b0, t0);
    gen_frame(VL, 1'b1, t0);
    checks++;
    if (rise_cyc !== t0 + 2 || vga.err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clear_relock rise=%0d err_cnt=%0d required %0d and 0", rise_cyc, vga.err_cnt, t0 + 2);
    end
  endtask
  task automatic test_bad_frame();
    int t0, rc;
    mode = 2;
    gen_frame(VL, 1'b1, t0);
    gen_frame(VL - 1, 1'b1, t0);
    rc = rise_cnt;
    gen_frame(VL - 1, 1'b0, t0);
    checks++;
    if (vga.err_cnt !== 8'd1 || vga.locked !== 1'b0) begin
      failures++;
      $display("FAIL bad_frame_loss err_cnt=%0d locked=%0b required 1 and 0", vga.err_cnt, vga.locked);
    end
    for (int f = 0; f < 3; f++) gen_frame(VL - 1, 1'b0, t0);
    gen_line(0, HP, 1'b1, 1'b0, -1);
    checks++;
    if (vga.locked !== 1'b0 || rise_cnt !== rc) begin
      failures++;
      $display("FAIL bad_frame_nolock locked=%0b rises=%0d required 0 and %0d", vga.locked, rise_cnt, rc);
    end
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL bad_frame_missing_wr pending=%0d required=0", sb.size());
    end
  endtask
  initial begin
    test_reset();
    test_lock();
    test_pixel();
    test_short_line();
    test_hold();
    test_async_clear();
    test_bad_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
